dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port (256x64 ROM + 256x64 RAM, 9-bit address) between two requesters: the core load/store unit (core_*) and the external loader/debug port (ext_*).
- Arbitrates between requesters, decodes ROM vs RAM from addr[8], sequences each access through a 3-state FSM and returns the response to the owning requester.
- ROM writes are rejected with an error response.

---
 rtl/params_pkg.sv | 40 ++++
 rtl/dmem_arb_grant.sv | 102 ++++++++++
 rtl/dmem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// -----------------------------------------------------------------------------
// params_pkg
// Shared widths, region decode constants and type definitions for the
// data-memory port arbiter (dmem_port_arbiter and dmem_arb_grant).
//
// Contents:
//   RISC_V_DATA_WIDTH          data word width (64)
//   DATA_MEMORY_ADDRESS_WIDTH  requester word-address width (9)
//   DMEM_REGION_BIT            address bit selecting RAM (1) vs ROM (0)
//   DMEM_ARB_STARVE_LIMIT      lost-contention count after which ext wins
//   DMEM_ARB_CNT_WIDTH         width of the starvation counter
//   dmem_arb_state_t           arbiter FSM states
//   dmem_req_id_t              requester identifier
//   dmem_is_rom_write()        helper: write request aimed at the ROM region
// -----------------------------------------------------------------------------
package params_pkg;

    parameter int RISC_V_DATA_WIDTH         = 64;
    parameter int DATA_MEMORY_ADDRESS_WIDTH = 9;
    parameter int DMEM_REGION_BIT           = 8;
    parameter int DMEM_ARB_STARVE_LIMIT     = 4;
    parameter int DMEM_ARB_CNT_WIDTH        = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } dmem_arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_EXT  = 1'b1
    } dmem_req_id_t;

    // ROM is read-only: any write with the region bit clear is an error.
    function automatic logic dmem_is_rom_write(input logic we, input logic region_ram);
        return we && !region_ram;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// -----------------------------------------------------------------------------
// dmem_arb_grant
// Grant selection for the two data-memory requesters (core, ext).
//
// Build option: macro DMEM_ARB_RR_EN
//   undefined : fixed priority to core, with a saturating starvation counter
//               that forces an ext grant after STARVE_LIMIT lost cycles.
//   defined   : round-robin; the requester not granted last wins contention.
//
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   core_valid  core request valid
//   ext_valid   ext request valid
//   idle        arbiter is in IDLE (the only cycle a grant is consumed)
//   grant       selected requester (meaningful when any valid is high)
// -----------------------------------------------------------------------------
module dmem_arb_grant
    import params_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT
)
`endif
(
    input  logic         clk,
    input  logic         rst,
    input  logic         core_valid,
    input  logic         ext_valid,
    input  logic         idle,
    output dmem_req_id_t grant
);

`ifdef DMEM_ARB_RR_EN

    dmem_req_id_t last_reg;
    dmem_req_id_t last_next;

    always_comb begin
        if (core_valid && ext_valid) begin
            grant = (last_reg == REQ_CORE) ? REQ_EXT : REQ_CORE;
        end else if (ext_valid) begin
            grant = REQ_EXT;
        end else begin
            grant = REQ_CORE;
        end
    end

    // Pointer follows every grant, contended or not.
    always_comb begin
        last_next = last_reg;
        if (idle && (core_valid || ext_valid)) begin
            last_next = grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= REQ_CORE;
        end else begin
            last_reg <= last_next;
        end
    end

`else

    localparam logic [DMEM_ARB_CNT_WIDTH-1:0] LIMIT = DMEM_ARB_CNT_WIDTH'(STARVE_LIMIT);

    logic [DMEM_ARB_CNT_WIDTH-1:0] starve_cnt_reg;
    logic [DMEM_ARB_CNT_WIDTH-1:0] starve_cnt_next;

    always_comb begin
        if (ext_valid && (!core_valid || (starve_cnt_reg == LIMIT))) begin
            grant = REQ_EXT;
        end else begin
            grant = REQ_CORE;
        end
    end

    // Counter only moves in IDLE. Ext "loses" exactly when it is valid but
    // the grant went to core; saturate so the forced win stays pending.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (idle) begin
            if (!ext_valid || (grant == REQ_EXT)) begin
                starve_cnt_next = '0;
            end else if (starve_cnt_reg != LIMIT) begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one data-memory port (256x64 ROM + 256x64 RAM) between the core
// load/store unit (core_*) and the external loader/debug port (ext_*).
// Each access runs IDLE (accept) -> ISSUE (memory enable) -> RESP (one-cycle
// response to the owner). Writes to the ROM region return err=1, rdata=0.
//
// Build option: macro DMEM_ARB_RR_EN selects round-robin arbitration;
// default is core priority with ext starvation protection (see dmem_arb_grant).
//
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   core_req_valid/ready/we/addr/wdata   core request handshake
//   core_rsp_valid/rdata/err             core one-cycle response
//   ext_req_* / ext_rsp_*                same for the external port
//   mem_rom_en, mem_ram_en, mem_we       memory enables (ISSUE cycle only)
//   mem_addr, mem_wdata                  word index and RAM write data
//   mem_rom_rdata, mem_ram_rdata         memory read data, valid the cycle
//                                        after the corresponding enable
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import params_pkg::*;
#(
    parameter int DATA_WIDTH   = RISC_V_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DATA_MEMORY_ADDRESS_WIDTH,
    parameter int STARVE_LIMIT = DMEM_ARB_STARVE_LIMIT
)
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    output logic                  core_rsp_err,

    input  logic                  ext_req_valid,
    output logic                  ext_req_ready,
    input  logic                  ext_req_we,
    input  logic [ADDR_WIDTH-1:0] ext_req_addr,
    input  logic [DATA_WIDTH-1:0] ext_req_wdata,
    output logic                  ext_rsp_valid,
    output logic [DATA_WIDTH-1:0] ext_rsp_rdata,
    output logic                  ext_rsp_err,

    output logic                  mem_rom_en,
    output logic                  mem_ram_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-2:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rom_rdata,
    input  logic [DATA_WIDTH-1:0] mem_ram_rdata
);

    dmem_arb_state_t       state_reg;
    dmem_arb_state_t       state_next;
    dmem_req_id_t          grant;
    dmem_req_id_t          owner_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  err_reg;

    logic                  is_idle;
    logic                  any_req;
    logic                  region_ram;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    assign is_idle    = (state_reg == ARB_IDLE);
    assign any_req    = core_req_valid || ext_req_valid;
    assign region_ram = addr_reg[DMEM_REGION_BIT];

    dmem_arb_grant
`ifndef DMEM_ARB_RR_EN
    #(
        .STARVE_LIMIT (STARVE_LIMIT)
    )
`endif
    u_grant (
        .clk        (clk),
        .rst        (rst),
        .core_valid (core_req_valid),
        .ext_valid  (ext_req_valid),
        .idle       (is_idle),
        .grant      (grant)
    );

    // ---------------- state register + request latch ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
            owner_reg <= REQ_CORE;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (is_idle && any_req) begin
                owner_reg <= grant;
                if (grant == REQ_EXT) begin
                    we_reg    <= ext_req_we;
                    addr_reg  <= ext_req_addr;
                    wdata_reg <= ext_req_wdata;
                end else begin
                    we_reg    <= core_req_we;
                    addr_reg  <= core_req_addr;
                    wdata_reg <= core_req_wdata;
                end
            end
            if (state_reg == ARB_ISSUE) begin
                err_reg <= dmem_is_rom_write(we_reg, region_ram);
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:  if (any_req) state_next = ARB_ISSUE;
            ARB_ISSUE: state_next = ARB_RESP;
            ARB_RESP:  state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Read data is passed straight from the memory during RESP (it arrives
    // one cycle after the ISSUE enable) so the response lands at accept+2.
    always_comb begin
        rsp_rdata = '0;
        if (!we_reg) begin
            rsp_rdata = region_ram ? mem_ram_rdata : mem_rom_rdata;
        end
    end

    always_comb begin
        core_req_ready = 1'b0;
        ext_req_ready  = 1'b0;
        mem_rom_en     = 1'b0;
        mem_ram_en     = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = addr_reg[DMEM_REGION_BIT-1:0];
        mem_wdata      = wdata_reg;
        core_rsp_valid = 1'b0;
        core_rsp_rdata = '0;
        core_rsp_err   = 1'b0;
        ext_rsp_valid  = 1'b0;
        ext_rsp_rdata  = '0;
        ext_rsp_err    = 1'b0;

        case (state_reg)
            ARB_IDLE: begin
                // Ready is masked during reset so nothing looks accepted
                // while the FSM is being held in IDLE.
                if (!rst) begin
                    core_req_ready = core_req_valid && (grant == REQ_CORE);
                    ext_req_ready  = ext_req_valid  && (grant == REQ_EXT);
                end
            end
            ARB_ISSUE: begin
                mem_ram_en = region_ram;
                mem_we     = region_ram && we_reg;
                mem_rom_en = !region_ram && !we_reg;
            end
            ARB_RESP: begin
                if (owner_reg == REQ_EXT) begin
                    ext_rsp_valid = 1'b1;
                    ext_rsp_rdata = rsp_rdata;
                    ext_rsp_err   = err_reg;
                end else begin
                    core_rsp_valid = 1'b1;
                    core_rsp_rdata = rsp_rdata;
                    core_rsp_err   = err_reg;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter: a table of single-requester
// accesses, a contention sequence (order depends on DMEM_ARB_RR_EN), and a
// reset-during-ISSUE sequence. Expected responses go into per-port queues
// when a request is accepted and are popped when the DUT answers.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        core_req_valid = 1'b0;
    logic        core_req_ready;
    logic        core_req_we = 1'b0;
    logic [8:0]  core_req_addr = '0;
    logic [63:0] core_req_wdata = '0;
    logic        core_rsp_valid;
    logic [63:0] core_rsp_rdata;
    logic        core_rsp_err;

    logic        ext_req_valid = 1'b0;
    logic        ext_req_ready;
    logic        ext_req_we = 1'b0;
    logic [8:0]  ext_req_addr = '0;
    logic [63:0] ext_req_wdata = '0;
    logic        ext_rsp_valid;
    logic [63:0] ext_rsp_rdata;
    logic        ext_rsp_err;

    logic        mem_rom_en;
    logic        mem_ram_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rom_rdata;
    logic [63:0] mem_ram_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_we    (core_req_we),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .core_rsp_err   (core_rsp_err),
        .ext_req_valid  (ext_req_valid),
        .ext_req_ready  (ext_req_ready),
        .ext_req_we     (ext_req_we),
        .ext_req_addr   (ext_req_addr),
        .ext_req_wdata  (ext_req_wdata),
        .ext_rsp_valid  (ext_rsp_valid),
        .ext_rsp_rdata  (ext_rsp_rdata),
        .ext_rsp_err    (ext_rsp_err),
        .mem_rom_en     (mem_rom_en),
        .mem_ram_en     (mem_ram_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rom_rdata  (mem_rom_rdata),
        .mem_ram_rdata  (mem_ram_rdata)
    );

    // ---------------- memory model: registered-read ROM and RAM ----------------
    function automatic logic [63:0] rom_val(input logic [7:0] a);
        if (a == 8'hFF) return 64'h1234;
        return {32'hC0DE_0000, 24'h0, a};
    endfunction

    bit   [63:0] ram [256];
    logic [63:0] ram_q = '0;
    logic [63:0] rom_q = '0;

    always @(posedge clk) begin
        if (mem_ram_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            ram_q <= ram[mem_addr];
        end
        if (mem_rom_en) rom_q <= rom_val(mem_addr);
    end
    assign mem_ram_rdata = ram_q;
    assign mem_rom_rdata = rom_q;

    // ---------------- scoreboard ----------------
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [64:0] core_q[$];
    logic [64:0] ext_q[$];

    typedef struct {
        bit          ext;
        bit          we;
        logic [8:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and retire any response.
    task automatic tick();
        logic [64:0] e;
        @(negedge clk);
        chk("ready_exclusive", {63'd0, core_req_ready & ext_req_ready}, 64'd0);
        if (core_rsp_valid) begin
            if (core_q.size() == 0) begin
                chk("core_rsp_unexpected", {63'd0, core_rsp_valid}, 64'd0);
            end else begin
                e = core_q.pop_front();
                chk("core_rsp_rdata", core_rsp_rdata, e[63:0]);
                chk("core_rsp_err", {63'd0, core_rsp_err}, {63'd0, e[64]});
            end
        end
        if (ext_rsp_valid) begin
            if (ext_q.size() == 0) begin
                chk("ext_rsp_unexpected", {63'd0, ext_rsp_valid}, 64'd0);
            end else begin
                e = ext_q.pop_front();
                chk("ext_rsp_rdata", ext_rsp_rdata, e[63:0]);
                chk("ext_rsp_err", {63'd0, ext_rsp_err}, {63'd0, e[64]});
            end
        end
    endtask

    task automatic set_req(input bit ext, input bit valid, input bit we,
                           input logic [8:0] a, input logic [63:0] d);
        if (ext) begin
            ext_req_valid = valid; ext_req_we = we; ext_req_addr = a; ext_req_wdata = d;
        end else begin
            core_req_valid = valid; core_req_we = we; core_req_addr = a; core_req_wdata = d;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_rom_en"}, {63'd0, mem_rom_en}, 64'd0);
        chk({tag, "_mem_ram_en"}, {63'd0, mem_ram_en}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, mem_we}, 64'd0);
        chk({tag, "_core_ready"}, {63'd0, core_req_ready}, 64'd0);
        chk({tag, "_ext_ready"}, {63'd0, ext_req_ready}, 64'd0);
        chk({tag, "_rsp_valid"}, {62'd0, core_rsp_valid, ext_rsp_valid}, 64'd0);
        chk({tag, "_rsp_err"}, {62'd0, core_rsp_err, ext_rsp_err}, 64'd0);
        chk({tag, "_core_rdata"}, core_rsp_rdata, 64'd0);
        chk({tag, "_ext_rdata"}, ext_rsp_rdata, 64'd0);
        chk({tag, "_mem_addr"}, {56'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    endtask

    // One access from a lone requester; called at a falling edge in IDLE.
    task automatic single_access(input vec_t v);
        bit got;
        bit exp_rom, exp_ram, exp_we;
        exp_rom = !v.addr[8] && !v.we;
        exp_ram = v.addr[8];
        exp_we  = v.addr[8] && v.we;
        set_req(v.ext, 1'b1, v.we, v.addr, v.wdata);
        if (v.ext) ext_q.push_back({v.exp_err, v.exp_rdata});
        else       core_q.push_back({v.exp_err, v.exp_rdata});
        got = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if ((v.ext ? ext_req_ready : core_req_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chk("accept", {63'd0, got}, 64'd1);
        if (!got) begin
            set_req(v.ext, 1'b0, 1'b0, '0, '0);
            if (v.ext) void'(ext_q.pop_back());
            else       void'(core_q.pop_back());
            return;
        end
        tick();                                 // ISSUE cycle (T+1)
        set_req(v.ext, 1'b0, 1'b0, '0, '0);
        chk("issue_rom_en", {63'd0, mem_rom_en}, {63'd0, exp_rom});
        chk("issue_ram_en", {63'd0, mem_ram_en}, {63'd0, exp_ram});
        chk("issue_we", {63'd0, mem_we}, {63'd0, exp_we});
        if (exp_rom || exp_ram) chk("issue_addr", {56'd0, mem_addr}, {56'd0, v.addr[7:0]});
        if (exp_we) chk("issue_wdata", mem_wdata, v.wdata);
        tick();                                 // RESP cycle (T+2)
        chk("resp_owner_valid", {63'd0, (v.ext ? ext_rsp_valid : core_rsp_valid)}, 64'd1);
        chk("resp_other_valid", {63'd0, (v.ext ? core_rsp_valid : ext_rsp_valid)}, 64'd0);
        tick();                                 // back to IDLE
        chk("resp_one_cycle", {62'd0, core_rsp_valid, ext_rsp_valid}, 64'd0);
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        bit exp_ext;

        vecs[0]  = '{1'b0, 1'b1, 9'h105, 64'hDEAD_BEEF, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 9'h105, 64'h0, 64'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 9'h010, 64'h1111, 64'h0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 9'h0FF, 64'h0, 64'h1234, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 9'h1AA, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 9'h1AA, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 9'h020, 64'h0, 64'hC0DE_0000_0000_0020, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 9'h0FF, 64'h77, 64'h0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 9'h105, 64'h0, 64'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 9'h0FF, 64'h0, 64'h1234, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 9'h1FF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 9'h1FF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        tick();
        rst = 1'b0;

        // Table of single-requester accesses
        for (int i = 0; i < 12; i++) begin
            single_access(vecs[i]);
            $display("vector %0d: %s %s addr=%h done", i, vecs[i].ext ? "ext" : "core",
                     vecs[i].we ? "write" : "read", vecs[i].addr);
        end

        // Contention from a fresh reset: both valid continuously
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 9'h105, '0);
        set_req(1'b1, 1'b1, 1'b0, 9'h0FF, '0);
        for (int g = 0; g < 10; g++) begin
`ifdef DMEM_ARB_RR_EN
            exp_ext = (g % 2 == 0);
`else
            exp_ext = (g % 5 == 4);
`endif
            #1;
            chk("grant_order", {62'd0, ext_req_ready, core_req_ready},
                exp_ext ? 64'd2 : 64'd1);
            if (ext_req_ready)       ext_q.push_back({1'b0, 64'h1234});
            else if (core_req_ready) core_q.push_back({1'b0, 64'hDEAD_BEEF});
            $display("grant %0d: core_ready=%0b ext_ready=%0b", g, core_req_ready, ext_req_ready);
            tick();
            if (g == 9) begin
                set_req(1'b0, 1'b0, 1'b0, '0, '0);
                set_req(1'b1, 1'b0, 1'b0, '0, '0);
            end
            tick();
            tick();
        end

        // Reset asserted during ISSUE of a core RAM write
        set_req(1'b0, 1'b1, 1'b1, 9'h133, 64'hABCD);
        #1;
        chk("abort_accept", {63'd0, core_req_ready}, 64'd1);
        tick();
        chk("abort_issue_ram_en", {63'd0, mem_ram_en}, 64'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("abort");
        tick();
        tick();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        $display("abort sequence done");
        // Aborted write must not have reached the RAM; next request works normally
        single_access('{1'b0, 1'b0, 9'h133, 64'h0, 64'h0, 1'b0});
        single_access('{1'b1, 1'b0, 9'h1AA, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0});

        chk("scoreboard_drain", 64'(core_q.size() + ext_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
